predictor_bht_param: RTL and testbench
======================================

Name: predictor_bht_param

Overview:
- Parametrised branch history table for the fetch/branch unit.
- Direct-mapped table of tagged saturating counters with a per-entry valid bit.
- Single-clock replacement for the dual-clock BHT. Adds valid-request handshakes, hit reporting, a clean allocate-on-miss policy, same-cycle predict/update forwarding, and a reset-driven table-clear sweep.

Parameters:
- ADDR_W, 11, branch address width.
- IDX_W, 8, index bits. Table depth is 2^IDX_W. Tag is addr[ADDR_W-1:IDX_W]. Requires ADDR_W > IDX_W.
- CTR_W, 2, saturating counter width. Requires CTR_W >= 1.
- INIT_CTR, 1, counter value written by the clear sweep and used as the starting point on allocation. Requires INIT_CTR < 2^CTR_W.
- MISS_PRED, 1, prediction returned on a table miss.

Ports:
- clock, input, 1, sole clock; all logic on posedge.
- reset, input, 1, synchronous, active-high.
- predict_valid, input, 1, prediction request strobe.
- predict_addr, input, ADDR_W, branch address to predict.
- prediction, output, 1, predicted direction (1 = taken).
- pred_hit, output, 1, 1 = tag matched a valid entry.
- pred_out_valid, output, 1, one-cycle pulse qualifying prediction and pred_hit.
- update_valid, input, 1, resolved-branch update strobe.
- update_addr, input, ADDR_W, resolved branch address.
- branch_result, input, 1, resolved direction (1 = taken).
- updated_state, output, CTR_W, counter value written by the last update.
- update_done, output, 1, one-cycle pulse qualifying updated_state.
- ready, output, 1, table initialised; requests are accepted only while ready = 1.

Behaviour:
- Reset (synchronous, active-high):
  - Any posedge with reset = 1 sets state = INIT and sweep pointer = 0.
  - Outputs go to: prediction = 0, pred_hit = 0, pred_out_valid = 0, updated_state = 0, update_done = 0, ready = 0.
  - Table contents are not trusted after reset.
- FSM states: INIT, RUN.
- INIT:
  - Each cycle with reset = 0, writes entry[ptr] = {valid = 0, tag = 0, ctr = INIT_CTR}, then ptr++.
  - After entry 2^IDX_W-1 is written, state = RUN and ready = 1 from the next cycle. Total: 2^IDX_W cycles after reset release.
  - predict_valid and update_valid are ignored: no pulses, no table writes.
  - Reset asserted mid-sweep restarts the sweep at ptr = 0.
- RUN: ready = 1 until the next reset. No other transition.
- Predict (1-cycle latency):
  - Triggered on a posedge with ready & predict_valid, using idx = predict_addr[IDX_W-1:0].
  - hit = entry.valid & (entry.tag == predict_addr[ADDR_W-1:IDX_W]).
  - Next cycle: pred_out_valid = 1, pred_hit = hit, prediction = hit ? ctr[CTR_W-1] : MISS_PRED.
  - pred_out_valid returns to 0 the cycle after. prediction and pred_hit hold their last values between requests.
- Update (1-cycle latency):
  - Triggered on a posedge with ready & update_valid, using idx = update_addr[IDX_W-1:0].
  - Base counter: the stored ctr on hit. On miss (invalid entry or tag mismatch), base = INIT_CTR; the stale counter is never reused.
  - New ctr, saturating: taken gives min(base+1, 2^CTR_W-1); not-taken gives max(base-1, 0).
  - Written entry = {valid = 1, tag = update_addr[ADDR_W-1:IDX_W], ctr = new}.
  - Next cycle: updated_state = new and update_done = 1 for one cycle. updated_state holds its value otherwise.
- Simultaneous predict and update in the same cycle:
  - Different index: both operations are independent.
  - Same index: predict observes the post-update entry (write-first forwarding). hit and ctr are computed from the newly written tag and counter.
- Back-to-back requests on consecutive cycles are accepted every cycle; there is no backpressure while ready = 1.
- The counter MSB is the prediction. No arithmetic wraps.

Test Plan:
- Reset 3 cycles, then release; pulse predict_valid at cycle 10 -> ready = 0 for exactly 256 cycles then 1; no pred_out_valid during INIT.
- After ready: predict 0x123 -> pred_out_valid pulse, pred_hit = 0, prediction = 1 (MISS_PRED).
- Update 0x123 taken on 3 consecutive cycles -> updated_state = 2, 3, 3 with three update_done pulses. Then predict 0x123 -> pred_hit = 1, prediction = 1.
- Alias: update 0x223 not-taken (same idx 0x23, new tag) -> allocate from INIT_CTR, updated_state = 0. Then predict 0x123 -> pred_hit = 0, prediction = 1; predict 0x223 -> pred_hit = 1, prediction = 0.
- Same cycle: update 0x045 taken (cold entry) and predict 0x045 -> updated_state = 2; pred_hit = 1, prediction = 1 (forwarded).
- Train 0x010 to ctr = 3, assert reset 1 cycle at sweep ptr 100 of a second reset's sweep -> ready low 256 cycles after the final release; predict 0x010 -> pred_hit = 0.

Source files
------------

// File: rtl/predictor_bht_param.sv
// Direct-mapped branch history table of tagged saturating counters.
// Single clock, reset-driven clear sweep, write-first predict/update forwarding.
module predictor_bht_param #(
  parameter int ADDR_W    = 11,
  parameter int IDX_W     = 8,
  parameter int CTR_W     = 2,
  parameter int INIT_CTR  = 1,
  parameter int MISS_PRED = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              predict_valid,
  input  logic [ADDR_W-1:0] predict_addr,
  output logic              prediction,
  output logic              pred_hit,
  output logic              pred_out_valid,
  input  logic              update_valid,
  input  logic [ADDR_W-1:0] update_addr,
  input  logic              branch_result,
  output logic [CTR_W-1:0]  updated_state,
  output logic              update_done,
  output logic              ready
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam logic [CTR_W-1:0] INIT_VAL = CTR_W'(INIT_CTR);
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};

  typedef enum logic {INIT, RUN} state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] ptr;

  logic             valid_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem   [DEPTH];
  logic [CTR_W-1:0] ctr_mem   [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) state <= INIT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      INIT:    if (ptr == IDX_W'(DEPTH - 1)) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset)              ptr <= '0;
    else if (state == INIT) ptr <= ptr + 1'b1;
  end

  assign ready = (state == RUN);

  logic do_predict, do_update;
  assign do_predict = ready & predict_valid & ~reset;
  assign do_update  = ready & update_valid  & ~reset;

  // Update path: a miss always restarts from INIT_VAL, never from the stale counter.
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic [CTR_W-1:0] u_base, u_new;

  assign u_idx  = update_addr[IDX_W-1:0];
  assign u_tag  = update_addr[ADDR_W-1:IDX_W];
  assign u_hit  = valid_mem[u_idx] & (tag_mem[u_idx] == u_tag);
  assign u_base = u_hit ? ctr_mem[u_idx] : INIT_VAL;

  always_comb begin
    u_new = u_base;
    if (branch_result) begin
      if (u_base != CTR_MAX) u_new = u_base + 1'b1;
    end else begin
      if (u_base != '0)      u_new = u_base - 1'b1;
    end
  end

  // Predict path sees the entry being written this same cycle.
  logic [IDX_W-1:0] p_idx;
  logic [TAG_W-1:0] p_tag;
  logic             p_fwd, p_valid, p_hit;
  logic [TAG_W-1:0] p_entry_tag;
  logic [CTR_W-1:0] p_ctr;

  assign p_idx       = predict_addr[IDX_W-1:0];
  assign p_tag       = predict_addr[ADDR_W-1:IDX_W];
  assign p_fwd       = do_update & (u_idx == p_idx);
  assign p_valid     = p_fwd ? 1'b1  : valid_mem[p_idx];
  assign p_entry_tag = p_fwd ? u_tag : tag_mem[p_idx];
  assign p_ctr       = p_fwd ? u_new : ctr_mem[p_idx];
  assign p_hit       = p_valid & (p_entry_tag == p_tag);

  // NOTE: the table arrays have no reset branch; the INIT sweep clears them, which keeps them mappable to RAM.
  always_ff @(posedge clock) begin
    if (!reset && state == INIT) begin
      valid_mem[ptr] <= 1'b0;
      tag_mem[ptr]   <= '0;
      ctr_mem[ptr]   <= INIT_VAL;
    end else if (do_update) begin
      valid_mem[u_idx] <= 1'b1;
      tag_mem[u_idx]   <= u_tag;
      ctr_mem[u_idx]   <= u_new;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prediction     <= 1'b0;
      pred_hit       <= 1'b0;
      pred_out_valid <= 1'b0;
      updated_state  <= '0;
      update_done    <= 1'b0;
    end else begin
      pred_out_valid <= do_predict;
      update_done    <= do_update;
      if (do_predict) begin
        pred_hit   <= p_hit;
        prediction <= p_hit ? p_ctr[CTR_W-1] : 1'(MISS_PRED);
      end
      if (do_update) updated_state <= u_new;
    end
  end

endmodule

// File: tb/tb_predictor_bht_param.sv
// Scoreboard bench for predictor_bht_param: expectations are queued at drive
// time and compared by a negedge monitor when the result pulses appear.
module tb_predictor_bht_param;

  localparam int ADDR_W = 11;
  localparam int CTR_W  = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              predict_valid = 1'b0;
  logic [ADDR_W-1:0] predict_addr = '0;
  logic              prediction, pred_hit, pred_out_valid;
  logic              update_valid = 1'b0;
  logic [ADDR_W-1:0] update_addr = '0;
  logic              branch_result = 1'b0;
  logic [CTR_W-1:0]  updated_state;
  logic              update_done, ready;

  typedef struct packed { logic hit; logic pred; } pred_exp_t;

  pred_exp_t        pred_q[$];
  logic [CTR_W-1:0] upd_q[$];
  int checks = 0;
  int errors = 0;

  predictor_bht_param dut (
    .clock(clock), .reset(reset),
    .predict_valid(predict_valid), .predict_addr(predict_addr),
    .prediction(prediction), .pred_hit(pred_hit), .pred_out_valid(pred_out_valid),
    .update_valid(update_valid), .update_addr(update_addr), .branch_result(branch_result),
    .updated_state(updated_state), .update_done(update_done), .ready(ready)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: any pulse without a queued expectation is a failure.
  always @(negedge clock) begin
    if (pred_out_valid) begin
      checks++;
      if (pred_q.size() == 0) begin
        errors++;
        $display("FAIL pred_unexpected: pred_out_valid=1 required no pulse (t=%0t)", $time);
      end else begin
        pred_exp_t e;
        e = pred_q.pop_front();
        if ({pred_hit, prediction} !== {e.hit, e.pred}) begin
          errors++;
          $display("FAIL pred_result: hit=%b pred=%b required hit=%b pred=%b (t=%0t)",
                   pred_hit, prediction, e.hit, e.pred, $time);
        end
      end
    end
    if (update_done) begin
      checks++;
      if (upd_q.size() == 0) begin
        errors++;
        $display("FAIL upd_unexpected: update_done=1 required no pulse (t=%0t)", $time);
      end else begin
        logic [CTR_W-1:0] e;
        e = upd_q.pop_front();
        if (updated_state !== e) begin
          errors++;
          $display("FAIL upd_state: updated_state=%0d required %0d (t=%0t)", updated_state, e, $time);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One accepted cycle; inputs stay as driven so back-to-back calls chain.
  task automatic step(input logic pv, input logic [ADDR_W-1:0] pa, input logic eh, input logic ep,
                      input logic uv, input logic [ADDR_W-1:0] ua, input logic br,
                      input logic [CTR_W-1:0] eu);
    pred_exp_t pe;
    predict_valid = pv; predict_addr = pa;
    update_valid  = uv; update_addr  = ua; branch_result = br;
    if (pv) begin pe.hit = eh; pe.pred = ep; pred_q.push_back(pe); end
    if (uv) upd_q.push_back(eu);
    tick();
  endtask

  task automatic idle();
    predict_valid = 1'b0;
    update_valid  = 1'b0;
    tick();
  endtask

  task automatic predict(input logic [ADDR_W-1:0] a, input logic eh, input logic ep);
    step(1'b1, a, eh, ep, 1'b0, '0, 1'b0, '0);
    idle();
  endtask

  task automatic update(input logic [ADDR_W-1:0] a, input logic br, input logic [CTR_W-1:0] eu);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, a, br, eu);
    idle();
  endtask

  // Counts cycles until ready; a predict pulse at cycle 10 must be ignored.
  task automatic wait_ready(output int n);
    n = 0;
    while (n < 1000) begin
      tick();
      n++;
      predict_valid = (n == 10);
      predict_addr  = 11'h123;
      if (ready) break;
    end
    predict_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({ready, pred_out_valid, update_done, pred_hit, prediction, updated_state} !== '0) begin
      errors++;
      $display("FAIL %s: ready=%b pov=%b ud=%b hit=%b pred=%b us=%0d required all 0",
               tag, ready, pred_out_valid, update_done, pred_hit, prediction, updated_state);
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset_outputs");
    reset = 1'b0;
    wait_ready(n);
    checks++;
    if (n !== 256) begin
      errors++;
      $display("FAIL init_length: ready after %0d cycles required 256", n);
    end
  endtask

  task automatic test_miss();
    predict(11'h123, 1'b0, 1'b1);
  endtask

  task automatic test_train();
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 11'h123, 1'b1, 2'd2);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 11'h123, 1'b1, 2'd3);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 11'h123, 1'b1, 2'd3);
    idle();
    predict(11'h123, 1'b1, 1'b1);
  endtask

  task automatic test_alias();
    update(11'h223, 1'b0, 2'd0);
    predict(11'h123, 1'b0, 1'b1);
    predict(11'h223, 1'b1, 1'b0);
    idle();
    checks++;
    if ({pred_hit, prediction} !== 2'b10) begin
      errors++;
      $display("FAIL pred_hold: hit=%b pred=%b required hit=1 pred=0", pred_hit, prediction);
    end
  endtask

  task automatic test_same_cycle();
    step(1'b1, 11'h045, 1'b1, 1'b1, 1'b1, 11'h045, 1'b1, 2'd2);
    idle();
  endtask

  task automatic test_back_to_back();
    step(1'b1, 11'h223, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    step(1'b1, 11'h045, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
    step(1'b1, 11'h0ff, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
    idle();
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 11'h223, 1'b0, 2'd0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 11'h223, 1'b1, 2'd1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 11'h223, 1'b1, 2'd2);
    idle();
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    update(11'h010, 1'b1, 2'd2);
    update(11'h010, 1'b1, 2'd3);
    predict(11'h010, 1'b1, 1'b1);
    reset = 1'b1;
    tick();
    check_reset_outputs("reset_mid_outputs");
    reset = 1'b0;
    repeat (100) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_ready(n);
    checks++;
    if (n !== 256) begin
      errors++;
      $display("FAIL restart_length: ready after %0d cycles required 256", n);
    end
    predict(11'h010, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_miss();
    test_train();
    test_alias();
    test_same_cycle();
    test_back_to_back();
    test_reset_mid_sweep();
    repeat (3) tick();
    checks++;
    if (pred_q.size() != 0 || upd_q.size() != 0) begin
      errors++;
      $display("FAIL pending: %0d predict and %0d update results missing, required 0",
               pred_q.size(), upd_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
